// File: rtl/async_fifo_prog_pkg.sv
// rtl/async_fifo_prog_pkg.sv - pointer width and gray-code helpers for async_fifo_prog
// Purpose: shared helpers for the dual-clock FIFO and its synchronizers.
// Ports: none (package).
package async_fifo_prog_pkg;

  // Widest pointer supported: ADDR_W up to 12 gives a 13-bit wrap pointer.
  localparam int PTR_MAX_W = 13;

  typedef logic [PTR_MAX_W-1:0] ptr_max_t;

  // Pointer carries one extra bit so full and empty are distinguishable.
  function automatic int ptr_w(input int addr_w);
    return addr_w + 1;
  endfunction

  // Callers zero-extend narrower pointers into ptr_max_t and truncate the result;
  // leading zeros do not disturb either conversion.
  function automatic ptr_max_t bin2gray(input ptr_max_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_max_t gray2bin(input ptr_max_t g);
    ptr_max_t b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/cdc_sync_vec.sv
// rtl/cdc_sync_vec.sv - multi-flop synchronizer for a gray-coded vector
// Purpose: carries a gray pointer into the destination clock domain.
// Ports: i_clk/i_reset_n destination clock and async active-low reset,
//        i_d source-domain vector, o_q synchronized vector (resets to zero).
module cdc_sync_vec #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_sync [STAGES];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/async_fifo_prog.sv
// rtl/async_fifo_prog.sv - dual-clock FIFO with programmable thresholds and sticky error flags
// Purpose: moves words from the wr_clk domain to the rd_clk domain.
// Ports: write side wr_clk/wr_reset_n, wr_en/wr_data, afull_thr, wr_clr_ovf -> full, afull,
//        wr_level, overflow. Read side rd_clk/rd_reset_n, rd_en, aempty_thr, rd_clr_udf ->
//        rd_data, rd_valid, empty, aempty, rd_level, underflow.
module async_fifo_prog
  import async_fifo_prog_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FWFT        = 1
) (
  input  logic              wr_clk,
  input  logic              wr_reset_n,
  input  logic              rd_clk,
  input  logic              rd_reset_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W:0]   afull_thr,
  input  logic              wr_clr_ovf,
  output logic              full,
  output logic              afull,
  output logic [ADDR_W:0]   wr_level,
  output logic              overflow,
  input  logic              rd_en,
  input  logic [ADDR_W:0]   aempty_thr,
  input  logic              rd_clr_udf,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              aempty,
  output logic [ADDR_W:0]   rd_level,
  output logic              underflow
);

  localparam int PW = ptr_w(ADDR_W);
  localparam int DP = 1 << ADDR_W;
  localparam logic [PW-1:0] LP_DEPTH = PW'(DP);

  logic [DATA_W-1:0] r_mem [DP];

  logic [PW-1:0] r_wr_ptr, r_wr_gray, r_rd_ptr, r_rd_gray;
  logic [PW-1:0] w_wr_ptr_nxt, w_rd_ptr_nxt;
  logic [PW-1:0] w_rd_gray_sync, w_wr_gray_sync;
  logic [PW-1:0] w_sync_rd_ptr, w_sync_wr_ptr;
  logic [PW-1:0] w_wr_level, w_rd_level;
  logic          w_full, w_empty, w_wr_do, w_rd_do;
  logic          r_overflow, r_underflow;

  // ---------------- write domain ----------------
  cdc_sync_vec #(.W(PW), .STAGES(SYNC_STAGES)) u_sync_rd2wr (
    .i_clk     (wr_clk),
    .i_reset_n (wr_reset_n),
    .i_d       (r_rd_gray),
    .o_q       (w_rd_gray_sync)
  );

  assign w_sync_rd_ptr = PW'(gray2bin(PTR_MAX_W'(w_rd_gray_sync)));
  // Lagging view of the read pointer makes the level an over-estimate, never an under-estimate.
  assign w_wr_level    = r_wr_ptr - w_sync_rd_ptr;
  assign w_full        = (w_wr_level == LP_DEPTH);
  assign w_wr_do       = wr_en & ~w_full;
  assign w_wr_ptr_nxt  = r_wr_ptr + PW'(w_wr_do);

  always_ff @(posedge wr_clk or negedge wr_reset_n) begin
    if (!wr_reset_n) begin
      r_wr_ptr   <= '0;
      r_wr_gray  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_wr_ptr  <= w_wr_ptr_nxt;
      // Gray copy is registered so the crossing bus never carries combinational glitches.
      r_wr_gray <= PW'(bin2gray(PTR_MAX_W'(w_wr_ptr_nxt)));
      if (wr_clr_ovf) begin
        r_overflow <= 1'b0;
      end else if (wr_en && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge wr_clk) begin
    if (w_wr_do) begin
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= wr_data;
    end
  end

  assign full     = w_full;
  assign afull    = (w_wr_level >= afull_thr);
  assign wr_level = w_wr_level;
  assign overflow = r_overflow;

  // ---------------- read domain ----------------
  cdc_sync_vec #(.W(PW), .STAGES(SYNC_STAGES)) u_sync_wr2rd (
    .i_clk     (rd_clk),
    .i_reset_n (rd_reset_n),
    .i_d       (r_wr_gray),
    .o_q       (w_wr_gray_sync)
  );

  assign w_sync_wr_ptr = PW'(gray2bin(PTR_MAX_W'(w_wr_gray_sync)));
  assign w_rd_level    = w_sync_wr_ptr - r_rd_ptr;
  assign w_empty       = (w_rd_level == '0);
  assign w_rd_do       = rd_en & ~w_empty;
  assign w_rd_ptr_nxt  = r_rd_ptr + PW'(w_rd_do);

  always_ff @(posedge rd_clk or negedge rd_reset_n) begin
    if (!rd_reset_n) begin
      r_rd_ptr    <= '0;
      r_rd_gray   <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_rd_ptr  <= w_rd_ptr_nxt;
      r_rd_gray <= PW'(bin2gray(PTR_MAX_W'(w_rd_ptr_nxt)));
      if (rd_clr_udf) begin
        r_underflow <= 1'b0;
      end else if (rd_en && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is visible as soon as it is known to be present.
      assign rd_data  = r_mem[r_rd_ptr[ADDR_W-1:0]];
      assign rd_valid = ~w_empty;
    end else begin : g_regd
      logic [DATA_W-1:0] r_rd_data;
      logic              r_rd_valid;

      always_ff @(posedge rd_clk or negedge rd_reset_n) begin
        if (!rd_reset_n) begin
          r_rd_data  <= '0;
          r_rd_valid <= 1'b0;
        end else begin
          r_rd_valid <= w_rd_do;
          if (w_rd_do) begin
            r_rd_data <= r_mem[r_rd_ptr[ADDR_W-1:0]];
          end
        end
      end

      assign rd_data  = r_rd_data;
      assign rd_valid = r_rd_valid;
    end
  endgenerate

  assign empty     = w_empty;
  assign aempty    = (w_rd_level <= aempty_thr);
  assign rd_level  = w_rd_level;
  assign underflow = r_underflow;

`ifndef SYNTHESIS
  a_wr_gray_step: assert property (@(posedge wr_clk) disable iff (!wr_reset_n)
    $countones(r_wr_gray ^ $past(r_wr_gray)) <= 1);
  a_rd_gray_step: assert property (@(posedge rd_clk) disable iff (!rd_reset_n)
    $countones(r_rd_gray ^ $past(r_rd_gray)) <= 1);
`endif

endmodule

// File: tb/tb_async_fifo_prog.sv
// tb/tb_async_fifo_prog.sv - directed and random checks of async_fifo_prog (FWFT and registered)
`timescale 1ns/1ps
module tb_async_fifo_prog;

  logic       wr_clk = 1'b0, rd_clk = 1'b0;
  logic       wr_reset_n = 1'b0, rd_reset_n = 1'b0;
  logic [7:0] wr_data = '0;
  logic [2:0] afull_thr = 3'd3, aempty_thr = 3'd1;
  logic       wr_clr_ovf = 1'b0, rd_clr_udf = 1'b0;
  real        wr_half = 5.0, rd_half = 8.5;

  logic       wr_en_a = 1'b0, rd_en_a = 1'b0;
  logic       full_a, afull_a, overflow_a, rd_valid_a, empty_a, aempty_a, underflow_a;
  logic [2:0] wr_level_a, rd_level_a;
  logic [7:0] rd_data_a;

  logic       wr_en_b = 1'b0, rd_en_b = 1'b0;
  logic       full_b, afull_b, overflow_b, rd_valid_b, empty_b, aempty_b, underflow_b;
  logic [2:0] wr_level_b, rd_level_b;
  logic [7:0] rd_data_b;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] q[$];

  always #(wr_half) wr_clk = ~wr_clk;
  always #(rd_half) rd_clk = ~rd_clk;

  async_fifo_prog #(.DATA_W(8), .ADDR_W(2), .SYNC_STAGES(2), .FWFT(1)) dut_a (
    .wr_clk(wr_clk), .wr_reset_n(wr_reset_n), .rd_clk(rd_clk), .rd_reset_n(rd_reset_n),
    .wr_en(wr_en_a), .wr_data(wr_data), .afull_thr(afull_thr), .wr_clr_ovf(wr_clr_ovf),
    .full(full_a), .afull(afull_a), .wr_level(wr_level_a), .overflow(overflow_a),
    .rd_en(rd_en_a), .aempty_thr(aempty_thr), .rd_clr_udf(rd_clr_udf),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a), .empty(empty_a), .aempty(aempty_a),
    .rd_level(rd_level_a), .underflow(underflow_a)
  );

  async_fifo_prog #(.DATA_W(8), .ADDR_W(2), .SYNC_STAGES(2), .FWFT(0)) dut_b (
    .wr_clk(wr_clk), .wr_reset_n(wr_reset_n), .rd_clk(rd_clk), .rd_reset_n(rd_reset_n),
    .wr_en(wr_en_b), .wr_data(wr_data), .afull_thr(afull_thr), .wr_clr_ovf(wr_clr_ovf),
    .full(full_b), .afull(afull_b), .wr_level(wr_level_b), .overflow(overflow_b),
    .rd_en(rd_en_b), .aempty_thr(aempty_thr), .rd_clr_udf(rd_clr_udf),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b), .empty(empty_b), .aempty(aempty_b),
    .rd_level(rd_level_b), .underflow(underflow_b)
  );

  task automatic wait_sync();
    repeat (5) @(negedge rd_clk);
    repeat (5) @(negedge wr_clk);
  endtask

  task automatic check_reset_values(input string tag);
    n_checks++; if (full_a !== 1'b0) begin n_fail++; $display("FAIL %s full_a: got %b want 0", tag, full_a); end
    n_checks++; if (afull_a !== 1'b0) begin n_fail++; $display("FAIL %s afull_a: got %b want 0", tag, afull_a); end
    n_checks++; if (wr_level_a !== 3'd0) begin n_fail++; $display("FAIL %s wr_level_a: got %0d want 0", tag, wr_level_a); end
    n_checks++; if (overflow_a !== 1'b0) begin n_fail++; $display("FAIL %s overflow_a: got %b want 0", tag, overflow_a); end
    n_checks++; if (empty_a !== 1'b1) begin n_fail++; $display("FAIL %s empty_a: got %b want 1", tag, empty_a); end
    n_checks++; if (aempty_a !== 1'b1) begin n_fail++; $display("FAIL %s aempty_a: got %b want 1", tag, aempty_a); end
    n_checks++; if (rd_level_a !== 3'd0) begin n_fail++; $display("FAIL %s rd_level_a: got %0d want 0", tag, rd_level_a); end
    n_checks++; if (rd_valid_a !== 1'b0) begin n_fail++; $display("FAIL %s rd_valid_a: got %b want 0", tag, rd_valid_a); end
    n_checks++; if (underflow_a !== 1'b0) begin n_fail++; $display("FAIL %s underflow_a: got %b want 0", tag, underflow_a); end
    n_checks++; if (rd_data_b !== 8'h00) begin n_fail++; $display("FAIL %s rd_data_b: got %h want 00", tag, rd_data_b); end
    n_checks++; if (rd_valid_b !== 1'b0) begin n_fail++; $display("FAIL %s rd_valid_b: got %b want 0", tag, rd_valid_b); end
    n_checks++; if (empty_b !== 1'b1) begin n_fail++; $display("FAIL %s empty_b: got %b want 1", tag, empty_b); end
  endtask

  task automatic test_reset();
    wr_reset_n = 1'b0; rd_reset_n = 1'b0;
    repeat (4) @(negedge wr_clk);
    repeat (4) @(negedge rd_clk);
    check_reset_values("reset_held");
    #2; wr_reset_n = 1'b1; rd_reset_n = 1'b1;
    @(negedge rd_clk); @(negedge wr_clk);
    check_reset_values("reset_released");
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      @(negedge wr_clk);
      if (i == 2) begin
        n_checks++; if (afull_a !== 1'b0) begin n_fail++; $display("FAIL fill_afull_lvl2: got %b want 0", afull_a); end
      end
      if (i == 3) begin
        n_checks++; if (wr_level_a !== 3'd3) begin n_fail++; $display("FAIL fill_level3: got %0d want 3", wr_level_a); end
        n_checks++; if (afull_a !== 1'b1) begin n_fail++; $display("FAIL fill_afull_lvl3: got %b want 1", afull_a); end
        n_checks++; if (full_a !== 1'b0) begin n_fail++; $display("FAIL fill_full_lvl3: got %b want 0", full_a); end
      end
      wr_en_a = 1'b1; wr_data = 8'(8'h11 * (i + 1));
    end
    @(negedge wr_clk);
    n_checks++; if (full_a !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b want 1", full_a); end
    n_checks++; if (wr_level_a !== 3'd4) begin n_fail++; $display("FAIL fill_level4: got %0d want 4", wr_level_a); end
    wr_data = 8'h55;
    @(negedge wr_clk);
    wr_en_a = 1'b0;
    n_checks++; if (overflow_a !== 1'b1) begin n_fail++; $display("FAIL fill_overflow: got %b want 1", overflow_a); end
    n_checks++; if (wr_level_a !== 3'd4) begin n_fail++; $display("FAIL fill_level_after_ovf: got %0d want 4", wr_level_a); end
    wr_clr_ovf = 1'b1;
    @(negedge wr_clk);
    wr_clr_ovf = 1'b0;
    n_checks++; if (overflow_a !== 1'b0) begin n_fail++; $display("FAIL fill_ovf_clear: got %b want 0", overflow_a); end
  endtask

  task automatic test_drain();
    wait_sync();
    n_checks++; if (rd_level_a !== 3'd4) begin n_fail++; $display("FAIL drain_rd_level4: got %0d want 4", rd_level_a); end
    for (int i = 0; i < 4; i++) begin
      @(negedge rd_clk);
      n_checks++; if (rd_data_a !== 8'(8'h11 * (i + 1))) begin n_fail++; $display("FAIL drain_data%0d: got %h want %h", i, rd_data_a, 8'(8'h11 * (i + 1))); end
      n_checks++; if (rd_level_a !== 3'(4 - i)) begin n_fail++; $display("FAIL drain_level%0d: got %0d want %0d", i, rd_level_a, 4 - i); end
      n_checks++; if (aempty_a !== (i == 3)) begin n_fail++; $display("FAIL drain_aempty%0d: got %b want %b", i, aempty_a, (i == 3)); end
      rd_en_a = 1'b1;
    end
    @(negedge rd_clk);
    rd_en_a = 1'b0;
    n_checks++; if (empty_a !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b want 1", empty_a); end
    n_checks++; if (rd_valid_a !== 1'b0) begin n_fail++; $display("FAIL drain_rd_valid: got %b want 0", rd_valid_a); end
    // Extra read on empty sets underflow without moving the pointer.
    rd_en_a = 1'b1;
    @(negedge rd_clk);
    rd_en_a = 1'b0;
    n_checks++; if (underflow_a !== 1'b1) begin n_fail++; $display("FAIL udf_set: got %b want 1", underflow_a); end
    n_checks++; if (rd_level_a !== 3'd0) begin n_fail++; $display("FAIL udf_level: got %0d want 0", rd_level_a); end
    rd_clr_udf = 1'b1;
    @(negedge rd_clk);
    n_checks++; if (underflow_a !== 1'b0) begin n_fail++; $display("FAIL udf_clear: got %b want 0", underflow_a); end
    // Clear and set in the same cycle: clear wins, then the persisting condition re-sets.
    rd_en_a = 1'b1;
    @(negedge rd_clk);
    rd_clr_udf = 1'b0;
    n_checks++; if (underflow_a !== 1'b0) begin n_fail++; $display("FAIL udf_clear_wins: got %b want 0", underflow_a); end
    @(negedge rd_clk);
    rd_en_a = 1'b0;
    n_checks++; if (underflow_a !== 1'b1) begin n_fail++; $display("FAIL udf_reset_after_clear: got %b want 1", underflow_a); end
    rd_clr_udf = 1'b1;
    @(negedge rd_clk);
    rd_clr_udf = 1'b0;
    wait_sync();
    n_checks++; if (full_a !== 1'b0) begin n_fail++; $display("FAIL drain_full_release: got %b want 0", full_a); end
    n_checks++; if (wr_level_a !== 3'd0) begin n_fail++; $display("FAIL drain_wr_level: got %0d want 0", wr_level_a); end
  endtask

  task automatic test_registered();
    @(negedge wr_clk);
    wr_en_b = 1'b1; wr_data = 8'hA5;
    @(negedge wr_clk);
    wr_en_b = 1'b0;
    wait_sync();
    @(negedge rd_clk);
    n_checks++; if (empty_b !== 1'b0) begin n_fail++; $display("FAIL reg_not_empty: got %b want 0", empty_b); end
    n_checks++; if (rd_valid_b !== 1'b0) begin n_fail++; $display("FAIL reg_valid_idle: got %b want 0", rd_valid_b); end
    n_checks++; if (rd_data_b !== 8'h00) begin n_fail++; $display("FAIL reg_data_idle: got %h want 00", rd_data_b); end
    rd_en_b = 1'b1;
    @(negedge rd_clk);
    rd_en_b = 1'b0;
    n_checks++; if (rd_valid_b !== 1'b1) begin n_fail++; $display("FAIL reg_valid_pulse: got %b want 1", rd_valid_b); end
    n_checks++; if (rd_data_b !== 8'hA5) begin n_fail++; $display("FAIL reg_data: got %h want a5", rd_data_b); end
    @(negedge rd_clk);
    n_checks++; if (rd_valid_b !== 1'b0) begin n_fail++; $display("FAIL reg_valid_end: got %b want 0", rd_valid_b); end
    n_checks++; if (rd_data_b !== 8'hA5) begin n_fail++; $display("FAIL reg_data_hold: got %h want a5", rd_data_b); end
    n_checks++; if (empty_b !== 1'b1) begin n_fail++; $display("FAIL reg_empty: got %b want 1", empty_b); end
  endtask

  task automatic test_thresholds();
    afull_thr = 3'd0;
    @(negedge wr_clk);
    n_checks++; if (afull_a !== 1'b1) begin n_fail++; $display("FAIL thr0_afull: got %b want 1", afull_a); end
    afull_thr = 3'd5; aempty_thr = 3'd4;
    for (int i = 0; i < 4; i++) begin
      @(negedge wr_clk);
      wr_en_a = 1'b1; wr_data = 8'(8'hC1 + i);
    end
    @(negedge wr_clk);
    wr_en_a = 1'b0;
    n_checks++; if (full_a !== 1'b1) begin n_fail++; $display("FAIL thr5_full: got %b want 1", full_a); end
    n_checks++; if (afull_a !== 1'b0) begin n_fail++; $display("FAIL thr5_afull: got %b want 0", afull_a); end
    wait_sync();
    n_checks++; if (aempty_a !== 1'b1) begin n_fail++; $display("FAIL thr4_aempty: got %b want 1", aempty_a); end
    for (int i = 0; i < 4; i++) begin
      @(negedge rd_clk);
      n_checks++; if (rd_data_a !== 8'(8'hC1 + i)) begin n_fail++; $display("FAIL wrap_data%0d: got %h want %h", i, rd_data_a, 8'(8'hC1 + i)); end
      rd_en_a = 1'b1;
    end
    @(negedge rd_clk);
    rd_en_a = 1'b0;
    afull_thr = 3'd3; aempty_thr = 3'd1;
    wait_sync();
  endtask

  task automatic run_random(input int n_words);
    int sent, got;
    logic [7:0] exp;
    sent = 0; got = 0;
    fork
      begin
        for (int c = 0; c < 20000 && sent < n_words; c++) begin
          @(negedge wr_clk);
          if (!full_a && ($urandom_range(0, 1) == 1)) begin
            wr_en_a = 1'b1; wr_data = 8'($urandom);
            q.push_back(wr_data);
            sent++;
          end else begin
            wr_en_a = 1'b0;
          end
        end
        @(negedge wr_clk);
        wr_en_a = 1'b0;
      end
      begin
        for (int c = 0; c < 20000 && got < n_words; c++) begin
          @(negedge rd_clk);
          if (!empty_a && ($urandom_range(0, 2) != 0)) begin
            n_checks++;
            if (q.size() == 0) begin
              n_fail++; $display("FAIL rand_scoreboard_empty: got %h want none", rd_data_a);
            end else begin
              exp = q.pop_front();
              if (rd_data_a !== exp) begin n_fail++; $display("FAIL rand_data%0d: got %h want %h", got, rd_data_a, exp); end
            end
            rd_en_a = 1'b1;
            got++;
          end else begin
            rd_en_a = 1'b0;
          end
        end
        @(negedge rd_clk);
        rd_en_a = 1'b0;
      end
    join
    n_checks++; if (got != n_words) begin n_fail++; $display("FAIL rand_timeout: got %0d want %0d", got, n_words); end
    wait_sync();
    n_checks++; if (empty_a !== 1'b1) begin n_fail++; $display("FAIL rand_empty: got %b want 1", empty_a); end
    n_checks++; if (wr_level_a !== 3'd0) begin n_fail++; $display("FAIL rand_wr_level: got %0d want 0", wr_level_a); end
    n_checks++; if (overflow_a !== 1'b0) begin n_fail++; $display("FAIL rand_overflow: got %b want 0", overflow_a); end
    n_checks++; if (underflow_a !== 1'b0) begin n_fail++; $display("FAIL rand_underflow: got %b want 0", underflow_a); end
  endtask

  task automatic test_wrap();
    run_random(500);
    wr_half = 8.5; rd_half = 5.0;
    run_random(500);
    wr_half = 5.0; rd_half = 8.5;
    wait_sync();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      @(negedge wr_clk);
      wr_en_a = 1'b1; wr_data = 8'(8'h61 + i);
    end
    @(negedge wr_clk);
    wr_en_a = 1'b0;
    wait_sync();
    n_checks++; if (rd_level_a !== 3'd2) begin n_fail++; $display("FAIL mid_level_before: got %0d want 2", rd_level_a); end
    test_reset();
    @(negedge wr_clk);
    wr_en_a = 1'b1; wr_data = 8'h77;
    @(negedge wr_clk);
    wr_en_a = 1'b0;
    wait_sync();
    @(negedge rd_clk);
    n_checks++; if (rd_data_a !== 8'h77) begin n_fail++; $display("FAIL mid_first_word: got %h want 77", rd_data_a); end
    n_checks++; if (rd_level_a !== 3'd1) begin n_fail++; $display("FAIL mid_level_after: got %0d want 1", rd_level_a); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_registered();
    test_thresholds();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
